// File: rtl/riscv_pipe_pkg.sv
// Shared constants for the F/D/E/M/W pipeline hazard logic.
// State encoding, forward selects and register address width.
package riscv_pipe_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_sequencer_if.sv
// Data-memory req/ready handshake between the hazard
// sequencer (master) and the data memory (slave).
interface hazard_sequencer_if;

  logic mem_req;
  logic mem_ready;

  modport master (
    output mem_req,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    output mem_ready
  );

endinterface

// File: rtl/forward_unit.sv
// EX-stage operand forward select for one source register.
// The M-stage result takes priority over the W-stage result.
module forward_unit
  import riscv_pipe_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  regwrite_m,
  input  logic                  regwrite_w,
  output logic [1:0]            fwd
);

  logic hit_m;
  logic hit_w;

  assign hit_m = regwrite_m && (rd_m != '0)
              && (rd_m == rs);
  assign hit_w = regwrite_w && (rd_w != '0)
              && (rd_w == rs) && !hit_m;

  always_comb begin
    fwd = FWD_RF;
    unique case (1'b1)
      hit_m:   fwd = FWD_MEM;
      hit_w:   fwd = FWD_WB;
      default: fwd = FWD_RF;
    endcase
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline stall/flush/forward sequencer with data-memory wait FSM.
// Define HAZARD_PERF_CNT_EN to add saturating performance counters.
module hazard_sequencer
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TMO_W       = 8,
  parameter int unsigned PERF_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic                  LoadE,
  input  logic                  PCSrcE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  MemAccessM,
  hazard_sequencer_if.master    mem,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  mem_timeout_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]     stall_cycles,
  output logic [PERF_W-1:0]     flush_events,
  output logic [PERF_W-1:0]     mem_wait_cycles
`endif
);

  if ((64'd1 << TMO_W) <= 64'(MEM_TIMEOUT)
      || PERF_W == 0) begin : g_bad_cfg
    $error("hazard_sequencer: TMO_W too narrow or PERF_W zero");
  end

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(MEM_TIMEOUT);

  state_t           state, state_n;
  logic [TMO_W-1:0] wait_cnt, cnt_n;
  logic             err_q, err_n;
  logic             hold, resolve;
  logic             miss, lu;
  logic [1:0]       fwd_a, fwd_b;

  forward_unit u_fwd_a (
    .rs         (Rs1E),
    .rd_m       (RdM),
    .rd_w       (RdW),
    .regwrite_m (RegWriteM),
    .regwrite_w (RegWriteW),
    .fwd        (fwd_a)
  );

  forward_unit u_fwd_b (
    .rs         (Rs2E),
    .rd_m       (RdM),
    .rd_w       (RdW),
    .regwrite_m (RegWriteM),
    .regwrite_w (RegWriteW),
    .fwd        (fwd_b)
  );

  assign miss = MemAccessM && !mem.mem_ready;
  assign lu   = LoadE && (RdE != '0)
             && (RdE == Rs1D || RdE == Rs2D);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= cnt_n;
      err_q    <= err_n;
    end
  end

  // hold freezes the whole pipe; resolve lets branch/load-use act
  always_comb begin
    state_n = state;
    cnt_n   = wait_cnt;
    err_n   = err_q;
    hold    = 1'b0;
    resolve = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (miss) begin
          hold    = 1'b1;
          state_n = ST_MEM_WAIT;
          cnt_n   = TMO_W'(1);
        end else begin
          resolve = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem.mem_ready) begin
          resolve = 1'b1;
          state_n = ST_RUN;
          cnt_n   = '0;
        end else begin
          hold = 1'b1;
          if (wait_cnt == TMO_LIM) begin
            state_n = ST_ERROR;
            err_n   = 1'b1;
          end else if (~&wait_cnt) begin
            cnt_n = wait_cnt + TMO_W'(1);
          end
        end
      end
      ST_ERROR: begin
        hold  = 1'b1;
        err_n = 1'b1;
      end
      default: state_n = ST_RUN;
    endcase
  end

  assign StallF = rst_n && (hold || (resolve && !PCSrcE && lu));
  assign StallD = StallF;
  assign StallE = rst_n && hold;
  assign StallM = rst_n && hold;
  assign FlushD = rst_n && resolve && PCSrcE;
  assign FlushE = rst_n && resolve && (PCSrcE || lu);
  assign FlushW = rst_n && hold;

  assign ForwardAE = rst_n ? fwd_a : FWD_RF;
  assign ForwardBE = rst_n ? fwd_b : FWD_RF;

  assign mem.mem_req     = rst_n && MemAccessM && (state != ST_ERROR);
  assign mem_timeout_err = err_q;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles    <= '0;
      flush_events    <= '0;
      mem_wait_cycles <= '0;
    end else begin
      if (StallF && ~&stall_cycles)
        stall_cycles <= stall_cycles + PERF_W'(1);
      if (FlushE && ~&flush_events)
        flush_events <= flush_events + PERF_W'(1);
      if (state == ST_MEM_WAIT && ~&mem_wait_cycles)
        mem_wait_cycles <= mem_wait_cycles + PERF_W'(1);
    end
  end
`endif

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
Pipeline hazard and stall sequencer for the 5-stage RISC-V core (F/D/E/M/W).
- Generates the EX-stage forwarding selects.
- Inserts load-use bubbles and flushes wrong-path instructions on taken branches/jumps.
- Freezes the pipeline during multi-cycle data-memory accesses via a req/ready handshake with timeout.
- Sits beside the controller/datapath; drives every pipeline-register enable and clear.

Parameters:
MEM_TIMEOUT, 255, max consecutive cycles in MEM_WAIT before declaring a bus error
TMO_W, 8, width of the wait counter; must satisfy 2^TMO_W > MEM_TIMEOUT
PERF_W, 32, width of performance counters (only with optional feature)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
Rs1D, Rs2D  in  5 each  source registers in Decode
Rs1E, Rs2E, RdE  in  5 each  source/destination registers in Execute
LoadE  in  1  instruction in Execute is a load
PCSrcE  in  1  branch taken or jump in Execute
RdM, RdW  in  5 each  destination registers in Memory/Writeback
RegWriteM, RegWriteW  in  1 each  destination write enables
MemAccessM  in  1  load or store in Memory stage
mem_ready  in  1  data memory completes the current access this cycle
mem_req  out  1  data memory request
StallF, StallD, StallE, StallM  out  1 each  hold pipeline register (enable = ~Stall)
FlushD, FlushE, FlushW  out  1 each  synchronous clear of D/E/W pipeline registers
ForwardAE, ForwardBE  out  2 each  ALU operand select: 00 regfile, 01 from W, 10 from M
mem_timeout_err  out  1  sticky bus-timeout flag

Behaviour:
- States: RUN, MEM_WAIT, ERROR; 2-bit state register plus TMO_W-bit wait_cnt.
- Reset (async, rst_n=0):
  - state=RUN, wait_cnt=0, mem_timeout_err=0.
  - All stall/flush outputs, mem_req and forwards are 0 while in reset.
- Forwarding (combinational, valid in every state):
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Else 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Else 00.
  - M has priority over W. ForwardBE is identical using Rs2E.
- mem_req = MemAccessM && (state==RUN || state==MEM_WAIT); 0 in ERROR.
- RUN:
  - MemAccessM && !mem_ready:
    - Go to MEM_WAIT, wait_cnt<=1.
    - This cycle: StallF/D/E/M=1, FlushW=1, FlushD=FlushE=0. The branch in E is held, not resolved.
  - Else if PCSrcE: FlushD=1, FlushE=1, no stalls. Branch wins over load-use because the D instruction is wrong-path.
  - Else if load-use (LoadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D)): StallF=1, StallD=1, FlushE=1 (exactly one bubble).
  - Zero-wait access (MemAccessM && mem_ready) causes no stall.
- MEM_WAIT:
  - mem_ready=1:
    - Release cycle: no memory stall, RUN branch/load-use rules apply combinationally this cycle.
    - Next state RUN, wait_cnt<=0.
  - mem_ready=0 and wait_cnt==MEM_TIMEOUT: go to ERROR, set mem_timeout_err.
  - Otherwise: wait_cnt<=wait_cnt+1, hold all four stalls and FlushW.
- ERROR:
  - StallF/D/E/M=1, FlushW=1, mem_req=0, mem_timeout_err=1.
  - Exit only via rst_n; mem_ready is ignored.
- wait_cnt saturates and never wraps.
- Reset asserted mid-MEM_WAIT forces RUN immediately and drops mem_req.

Optional Feature:
HAZARD_PERF_CNT_EN:
- Defined: adds outputs stall_cycles, flush_events, mem_wait_cycles (PERF_W each), all reset to 0.
  - stall_cycles increments on any cycle with StallF=1.
  - flush_events increments on any cycle with FlushE=1.
  - mem_wait_cycles increments on each cycle in MEM_WAIT.
  - Counters saturate at all-ones.
- Undefined: ports and counters are absent; core behaviour is unchanged.

Decomposition:
- Package riscv_pipe_pkg holds:
  - state encoding constants: ST_RUN=0, ST_MEM_WAIT=1, ST_ERROR=2
  - forward-select constants: FWD_RF=00, FWD_WB=01, FWD_MEM=10
  - REG_ADDR_W=5
- One combinational sub-module, forward_unit, instantiated once per operand (A and B). The FSM, stall/flush logic and counters stay in hazard_sequencer.

Test Plan:
- RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00; RdM=0 -> ForwardAE=01.
- LoadE=1, RdE=7, Rs2D=7, PCSrcE=0 -> StallF=StallD=FlushE=1 for one cycle; same with PCSrcE=1 -> FlushD=FlushE=1, StallF=0.
- MemAccessM=1, mem_ready low 3 cycles then high -> mem_req=1 for 4 cycles, StallM=1 for 3 cycles, FlushW=1 for 3 cycles, state back to RUN after the 4th cycle.
- MEM_TIMEOUT=4, MemAccessM=1, mem_ready=0 -> ERROR after the 5th cycle, mem_timeout_err=1 held, mem_req=0; mem_ready=1 later has no effect until rst_n pulse.
- PCSrcE=1 during MEM_WAIT -> no FlushD/E until the mem_ready cycle, then FlushD=FlushE=1 that cycle.
- rst_n low asynchronously mid-MEM_WAIT -> all outputs 0 immediately; with HAZARD_PERF_CNT_EN, counters read 0 after reset.
